// File: rtl/aes_pkg.sv
// Shared AES constants, state encoding and GF(2^8) helpers for the key schedule and round datapath.
package aes_pkg;

  localparam int unsigned AES_KEY_W  = 128;
  localparam int unsigned AES_NR     = 10;
  localparam logic [7:0]  RCON_INIT  = 8'h01;
  localparam logic [7:0]  XTIME_POLY = 8'h1b;

  typedef enum logic {IDLE, EMIT} state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Round-key stream interface: start/key request in, valid/ready round-key beats out.
interface aes_key_expand_if;
  import aes_pkg::*;

  logic                 start;
  logic [AES_KEY_W-1:0] key_in;
  logic                 busy;
  logic                 rk_valid;
  logic                 rk_ready;
  logic [AES_KEY_W-1:0] rk_out;
  logic [3:0]           rk_idx;
  logic                 done;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_out, rk_idx, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_out, rk_idx, done
  );

endinterface

// File: rtl/sbox.sv
// AES forward S-box; the byte is presented as row (high nibble x) and column (low nibble y).
module sbox (
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  output logic [7:0] s_o
);

  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the bit offset is 8 * (255 - index).
  logic [10:0] base;
  assign base = {~{x_i, y_i}, 3'b000};
  assign s_o  = SboxTable[base +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 as valid/ready beats, one per cycle.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NR
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_key_expand_if.slave   kif
);

  localparam logic [3:0] LastIdx = 4'(NUM_ROUNDS);

  state_e               state_q, state_d;
  logic [AES_KEY_W-1:0] key_q, key_d, next_key;
  logic [7:0]           rcon_q, rcon_d;
  logic [3:0]           idx_q, idx_d;
  logic                 done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    sbox u_sbox (
      .x_i (rot_w[8*i+4 +: 4]),
      .y_i (rot_w[8*i   +: 4]),
      .s_o (sub_w[8*i   +: 8])
    );
  end

  assign t        = sub_w ^ {rcon_q, 24'h000000};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (kif.start) begin
          key_d   = kif.key_in;
          idx_d   = 4'd0;
          rcon_d  = RCON_INIT;
          state_d = EMIT;
        end
      end
      EMIT: begin
        // start is deliberately not looked at here; only the consumer advances the schedule.
        if (kif.rk_ready) begin
          if (idx_q == LastIdx) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d  = next_key;
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      rcon_q  <= RCON_INIT;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign kif.rk_out   = key_q;
  assign kif.rk_idx   = idx_q;
  assign kif.rk_valid = (state_q == EMIT);
  assign kif.busy     = (state_q == EMIT);
  assign kif.done     = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand against a word-level FIPS-197 key expansion model.
module tb_aes_key_expand;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_expand_if kif ();

  aes_key_expand #(.NUM_ROUNDS(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] ref_rk   [11];
  logic [127:0] got      [11];
  int           nbeats, ncycles, stall_err, proto_err, idx_err;
  bit           done_ok;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, a8, b8;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      a8 = 8'(a);
      for (int b = 1; b < 256; b++) begin
        b8 = 8'(b);
        if (a != 0 && gmul(a8, b8) == 8'h01) inv = b8;
      end
      sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic ref_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref[tmp[31:24]], sbox_ref[tmp[23:16]], sbox_ref[tmp[15:8]], sbox_ref[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Drives one full expansion and records what was observed; the callers judge the results.
  task automatic run_exp(input logic [127:0] key, input int ready_pct, input int pulse_idx,
                         input logic [127:0] alt_key);
    logic [127:0] prev_out;
    logic [3:0]   prev_idx;
    bit           prev_stall, pulsed, rdy;
    prev_stall = 0; pulsed = 0; prev_out = '0; prev_idx = '0;
    nbeats = 0; ncycles = 0; stall_err = 0; proto_err = 0; idx_err = 0;
    kif.key_in = key;
    kif.start  = 1'b1;
    @(posedge clk); #1;
    kif.start = 1'b0;
    while (nbeats < 11 && ncycles < 1000) begin
      kif.start = 1'b0;
      if (kif.rk_valid !== 1'b1 || kif.busy !== 1'b1 || kif.done !== 1'b0) proto_err++;
      if (prev_stall && (kif.rk_out !== prev_out || kif.rk_idx !== prev_idx)) stall_err++;
      if (!pulsed && pulse_idx >= 0 && kif.rk_idx == 4'(pulse_idx)) begin
        kif.start  = 1'b1;
        kif.key_in = alt_key;
        pulsed     = 1;
      end
      rdy = ($urandom_range(99) < ready_pct);
      kif.rk_ready = rdy;
      if (rdy && kif.rk_valid === 1'b1) begin
        if (kif.rk_idx !== 4'(nbeats)) idx_err++;
        got[nbeats] = kif.rk_out;
        nbeats++;
      end
      prev_stall = !rdy;
      prev_out   = kif.rk_out;
      prev_idx   = kif.rk_idx;
      @(posedge clk); #1;
      ncycles++;
    end
    kif.rk_ready = 1'b0;
    kif.start    = 1'b0;
    done_ok = (kif.done === 1'b1 && kif.rk_valid === 1'b0 && kif.busy === 1'b0);
    @(posedge clk); #1;
    if (kif.done !== 1'b0) done_ok = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (kif.rk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", kif.rk_valid); end
    checks++; if (kif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", kif.busy); end
    checks++; if (kif.rk_out !== 128'h0) begin errors++; $display("FAIL reset_out: got %h want 0", kif.rk_out); end
    checks++; if (kif.rk_idx !== 4'h0) begin errors++; $display("FAIL reset_idx: got %h want 0", kif.rk_idx); end
    checks++; if (kif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", kif.done); end
    @(negedge clk);
    rst_n = 1'b1;
    kif.rk_ready = 1'b1;  // ready with no valid must do nothing
    repeat (3) @(posedge clk);
    #1;
    kif.rk_ready = 1'b0;
    checks++;
    if (kif.rk_valid !== 1'b0 || kif.rk_idx !== 4'h0 || kif.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got valid=%b idx=%0d done=%b want 0/0/0", kif.rk_valid, kif.rk_idx, kif.done);
    end
  endtask

  task automatic test_fips();
    logic [127:0] k;
    int bad;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ref_expand(k);
    run_exp(k, 100, -1, '0);
    bad = 0;
    for (int r = 0; r < 11; r++) if (got[r] !== ref_rk[r]) bad++;
    checks++; if (nbeats != 11) begin errors++; $display("FAIL fips_beats: got %0d want 11", nbeats); end
    checks++; if (ncycles != 11) begin errors++; $display("FAIL fips_back_to_back: got %0d cycles want 11", ncycles); end
    checks++; if (got[0] !== k) begin errors++; $display("FAIL fips_idx0: got %h want %h", got[0], k); end
    checks++; if (got[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      errors++; $display("FAIL fips_idx1: got %h want a0fafe1788542cb123a339392a6c7605", got[1]); end
    checks++; if (got[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL fips_idx10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got[10]); end
    checks++; if (bad != 0) begin errors++; $display("FAIL fips_model: got %0d wrong keys want 0", bad); end
    checks++; if (proto_err != 0 || idx_err != 0) begin
      errors++; $display("FAIL fips_protocol: got proto=%0d idx=%0d want 0/0", proto_err, idx_err); end
    checks++; if (!done_ok) begin errors++; $display("FAIL fips_done: got no single done pulse want one"); end
  endtask

  task automatic test_stall();
    logic [127:0] k;
    int bad;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    ref_expand(k);
    run_exp(k, 45, -1, '0);
    bad = 0;
    for (int r = 0; r < 11; r++) if (got[r] !== ref_rk[r]) bad++;
    checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", stall_err); end
    checks++; if (got[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      errors++; $display("FAIL stall_idx10: got %h want 13111d7fe3944a17f307a78b4d2b30c5", got[10]); end
    checks++; if (bad != 0 || idx_err != 0 || nbeats != 11) begin
      errors++; $display("FAIL stall_model: got bad=%0d idx_err=%0d beats=%0d want 0/0/11", bad, idx_err, nbeats); end
    checks++; if (!done_ok) begin errors++; $display("FAIL stall_done: got no single done pulse want one"); end
  endtask

  task automatic test_start_during_emit();
    logic [127:0] k1, k2;
    int bad;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k1;
    ref_expand(k1);
    run_exp(k1, 100, 4, k2);
    bad = 0;
    for (int r = 0; r < 11; r++) if (got[r] !== ref_rk[r]) bad++;
    checks++; if (bad != 0 || nbeats != 11) begin
      errors++; $display("FAIL emit_start_ignored: got bad=%0d beats=%0d want 0/11", bad, nbeats); end
    checks++; if (!done_ok || proto_err != 0) begin
      errors++; $display("FAIL emit_start_done: got done_ok=%0d proto=%0d want 1/0", done_ok, proto_err); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k;
    int cyc, bad, seen_done;
    k = {$urandom, $urandom, $urandom, $urandom};
    kif.key_in = k;
    kif.start  = 1'b1;
    @(posedge clk); #1;
    kif.start    = 1'b0;
    kif.rk_ready = 1'b1;
    cyc = 0;
    while (kif.rk_idx !== 4'd6 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (kif.rk_idx !== 4'd6) begin errors++; $display("FAIL rstmid_reach6: got %0d want 6", kif.rk_idx); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (kif.rk_valid !== 1'b0 || kif.busy !== 1'b0 || kif.rk_out !== 128'h0 || kif.rk_idx !== 4'h0) begin
      errors++;
      $display("FAIL rstmid_clear: got valid=%b busy=%b out=%h idx=%0d want all zero",
               kif.rk_valid, kif.busy, kif.rk_out, kif.rk_idx);
    end
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      if (kif.done !== 1'b0) seen_done++;
      @(posedge clk); #1;
    end
    kif.rk_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (kif.done !== 1'b0) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d done cycles want 0", seen_done); end
    k = {$urandom, $urandom, $urandom, $urandom};
    ref_expand(k);
    run_exp(k, 70, -1, '0);
    bad = 0;
    for (int r = 0; r < 11; r++) if (got[r] !== ref_rk[r]) bad++;
    checks++; if (bad != 0 || nbeats != 11 || !done_ok) begin
      errors++; $display("FAIL rstmid_restart: got bad=%0d beats=%0d done_ok=%0d want 0/11/1", bad, nbeats, done_ok); end
  endtask

  task automatic test_zero_key();
    run_exp(128'h0, 80, -1, '0);
    checks++; if (got[1] !== 128'h62636363626363636263636362636363) begin
      errors++; $display("FAIL zero_idx1: got %h want 62636363626363636263636362636363", got[1]); end
    checks++; if (got[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      errors++; $display("FAIL zero_idx10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", got[10]); end
  endtask

  task automatic test_start_held();
    logic [127:0] k;
    int cyc;
    k = {$urandom, $urandom, $urandom, $urandom};
    kif.key_in   = k;
    kif.start    = 1'b1;
    kif.rk_ready = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (kif.done !== 1'b1 && cyc < 40);
    checks++; if (cyc != 12) begin errors++; $display("FAIL held_done_time: got %0d cycles want 12", cyc); end
    checks++; if (kif.busy !== 1'b0 || kif.rk_valid !== 1'b0) begin
      errors++; $display("FAIL held_idle_gap: got busy=%b valid=%b want 0/0", kif.busy, kif.rk_valid); end
    @(posedge clk); #1;
    kif.start = 1'b0;
    checks++; if (kif.rk_valid !== 1'b1 || kif.rk_idx !== 4'd0 || kif.rk_out !== k) begin
      errors++; $display("FAIL held_restart: got valid=%b idx=%0d out=%h want 1/0/%h",
                         kif.rk_valid, kif.rk_idx, kif.rk_out, k); end
    cyc = 0;
    while (kif.done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    kif.rk_ready = 1'b0;
    checks++; if (kif.done !== 1'b1) begin errors++; $display("FAIL held_second_done: got 0 want 1"); end
    @(posedge clk); #1;
  endtask

  task automatic test_random_keys();
    logic [127:0] k;
    int bad;
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      ref_expand(k);
      run_exp(k, 30 + 30 * n, -1, '0);
      bad = 0;
      for (int r = 0; r < 11; r++) if (got[r] !== ref_rk[r]) bad++;
      checks++; if (bad != 0 || nbeats != 11 || stall_err != 0 || !done_ok) begin
        errors++; $display("FAIL random_key%0d: got bad=%0d beats=%0d stall=%0d done_ok=%0d want 0/11/0/1",
                           n, bad, nbeats, stall_err, done_ok); end
    end
  endtask

  initial begin
    kif.start    = 1'b0;
    kif.key_in   = '0;
    kif.rk_ready = 1'b0;
    build_sbox();
    test_reset();
    test_fips();
    test_stall();
    test_start_during_emit();
    test_reset_mid();
    test_zero_key();
    test_start_held();
    test_random_keys();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule. Takes a 128-bit cipher key and emits round keys 0..10 one per handshake beat.
- Feeds the round datapath, both the encrypt and decrypt round engines, with AddRoundKey operands.
- Consumes the forward S-box for SubWord, via four instances of the existing sbox module.

Parameters:
- NUM_ROUNDS, 10, number of expanded rounds; key 0 is the raw key. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin expansion of key_in; ignored unless the block is IDLE.
- key_in  in  128  cipher key. Byte 0 is the most significant byte; w0 = bytes 0..3.
- busy  out  1  high from the cycle after an accepted start until the last round key is accepted.
- rk_valid  out  1  rk_out/rk_idx hold a valid round key.
- rk_ready  in  1  consumer accepts the round key when rk_valid & rk_ready.
- rk_out  out  128  current round key, same byte order as key_in.
- rk_idx  out  4  round number of rk_out, 0..10.
- done  out  1  one-cycle pulse the cycle after round key 10 is accepted.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: busy=0, rk_valid=0, rk_out=0, rk_idx=0, done=0, rcon register=8'h01, state=IDLE.
- States: IDLE, EMIT.
- IDLE: on start=1, register key_in into the key register, set rk_idx=0 and rcon=8'h01, go to EMIT. rk_valid=1 and busy=1 from the next cycle, so latency start→first key is 1 cycle.
- EMIT, rk_valid=1:
  - If rk_ready=0: hold rk_out, rk_idx and rcon stable. No change is permitted while valid and not ready.
  - If rk_ready=1 and rk_idx<10: next cycle rk_out = next round key, rk_idx+1, rcon=xtime(rcon), rk_valid remains 1. Back-to-back acceptance gives one key per cycle.
  - If rk_ready=1 and rk_idx=10: next cycle rk_valid=0, busy=0, done=1 for one cycle, go to IDLE. rk_out keeps its last value.
- Next key computation, combinational from the current key register:
  - t = SubWord(RotWord(w3)) ^ {rcon,8'h00,8'h00,8'h00}.
  - RotWord: [b0,b1,b2,b3]→[b1,b2,b3,b0].
  - SubWord: each byte through the sbox, high nibble on x, low nibble on y.
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- rcon update: xtime(r) = (r<<1) ^ (r[msb] ? 8'h1b : 0), 8-bit result. Sequence: 01,02,04,08,10,20,40,80,1b,36. rcon is the value used to produce key idx+1.
- start during EMIT: ignored, with no effect on the key register, rcon or rk_idx.
- start in the same cycle as the final handshake: ignored. A new start is accepted only in IDLE, earliest in the done cycle.
- rk_ready while rk_valid=0: no effect.
- Reset mid-expansion: all state returns to reset values immediately. No done pulse is generated.
- The block is single-ported and fully registered on outputs, with no combinational path from rk_ready to rk_out.

Decomposition:
- Shared package aes_pkg:
  - AES_KEY_W=128, AES_NR=10, RCON_INIT=8'h01, XTIME_POLY=8'h1b.
  - xtime function, also reused by MixColumns.
  - State enum {IDLE, EMIT}.
- Sub-module: sbox, instanced four times for SubWord.
- No new sub-module. Rot/XOR/rcon logic stays inline.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1 constant:
  - idx0 = key.
  - idx1 = a0fafe1788542cb123a339392a6c7605.
  - idx10 = d014f9a8c9ee2589e13f0c c8b6630ca6 (i.e. d014f9a8c9ee2589e13f0cc8b6630ca6).
  - 11 consecutive valid beats, then a done pulse exactly 1 cycle after beat 10.
- Key 000102030405060708090a0b0c0d0e0f, rk_ready randomly deasserted:
  - rk_out/rk_idx stable while stalled.
  - idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
- start pulsed during EMIT at idx 4 with a different key_in → sequence unchanged, all 11 keys match the first key's schedule.
- rst_n asserted asynchronously mid-expansion at idx 6 → outputs zero immediately, no done. A subsequent start restarts at idx0 with correct keys.
- All-zero key → idx1 = 62636363626363636263636362636363, idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- start held high across done → a second expansion begins only from IDLE. busy goes low for at least the done cycle.
